// File: rtl/atom_sram_pkg.sv
// Shared types and constants for the Atom board SRAM sequencer/arbiter.
// Holds the access FSM state encoding, address width and requester ids.
package atom_sram_pkg;

  localparam int SRAM_ADDR_W = 18;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_AUX = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;

endpackage

// File: rtl/sram_arbiter_if.sv
// Request/response bundle for the CPU and aux SRAM requesters (level req held until one-cycle ack).
// master = requesters, slave = sram_arbiter.
interface sram_arbiter_if #(
  parameter int ADDR_W = 18
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [7:0]        cpu_wdata;
  logic [7:0]        cpu_rdata;
  logic              cpu_ack;

  logic              aux_req;
  logic              aux_we;
  logic [ADDR_W-1:0] aux_addr;
  logic [7:0]        aux_wdata;
  logic [7:0]        aux_rdata;
  logic              aux_ack;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ack,
    output aux_req, aux_we, aux_addr, aux_wdata,
    input  aux_rdata, aux_ack
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ack,
    input  aux_req, aux_we, aux_addr, aux_wdata,
    output aux_rdata, aux_ack
  );
endinterface

// File: rtl/sram_rr_arb.sv
// Two-port round-robin grant; last_grant moves only when the sequencer leaves IDLE.
// Combinational grant, one register; with SRAM_ARB_AUX_EN undefined the CPU always wins.
module sram_rr_arb
  import atom_sram_pkg::*;
(
  input  logic clk100,
  input  logic reset,
  input  logic cpu_req,
  input  logic aux_req,
  input  logic grant,
  output logic gnt_port
);

`ifdef SRAM_ARB_AUX_EN
  logic last_grant_q, last_grant_d;

  // On a tie the port that did not win last time gets the SRAM.
  always_comb begin
    gnt_port = PORT_CPU;
    if (cpu_req && aux_req) begin
      gnt_port = (last_grant_q == PORT_CPU) ? PORT_AUX : PORT_CPU;
    end else if (aux_req) begin
      gnt_port = PORT_AUX;
    end
    last_grant_d = grant ? gnt_port : last_grant_q;
  end

  always_ff @(posedge clk100 or posedge reset) begin
    if (reset) begin
      last_grant_q <= PORT_AUX;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`else
  wire unused_arb_inputs = ^{clk100, reset, cpu_req, aux_req, grant};
  assign gnt_port = PORT_CPU;
`endif

endmodule

// File: rtl/sram_arbiter.sv
// Sequencer for the 256Kx8 async SRAM: IDLE->SETUP->STROBE(ACCESS_CYCLES)->HOLD, ack in HOLD, all pins registered.
// Aux port and round-robin arbitration exist only when SRAM_ARB_AUX_EN is defined; otherwise aux is ignored.
module sram_arbiter
  import atom_sram_pkg::*;
#(
  parameter int ADDR_W        = SRAM_ADDR_W,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic              clk100,
  input  logic              reset,
  sram_arbiter_if.slave     bus,
  output logic              RAMCS_b,
  output logic              RAMOE_b,
  output logic              RAMWE_b,
  output logic [ADDR_W-1:0] ADR,
  output logic [7:0]        dat_out,
  output logic              dat_oe,
  input  logic [7:0]        dat_in
);

  localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              port_q, port_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [7:0]        dat_out_q, dat_out_d;
  logic              cs_b_q, cs_b_d, oe_b_q, oe_b_d, we_b_q, we_b_d;
  logic              dat_oe_q, dat_oe_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic [7:0]        cpu_rdata_q, cpu_rdata_d;

  logic              aux_req;
  logic              grant;
  logic              gnt_port;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [7:0]        sel_wdata;
  logic              rd_capture;

`ifdef SRAM_ARB_AUX_EN
  assign aux_req = bus.aux_req;
`else
  assign aux_req = 1'b0;
  wire unused_aux = ^{bus.aux_req, bus.aux_we, bus.aux_addr, bus.aux_wdata};
`endif

  assign grant = (state_q == IDLE) && (bus.cpu_req || aux_req);

  sram_rr_arb u_arb (
    .clk100   (clk100),
    .reset    (reset),
    .cpu_req  (bus.cpu_req),
    .aux_req  (aux_req),
    .grant    (grant),
    .gnt_port (gnt_port)
  );

  always_comb begin
    sel_we    = bus.cpu_we;
    sel_addr  = bus.cpu_addr;
    sel_wdata = bus.cpu_wdata;
`ifdef SRAM_ARB_AUX_EN
    if (gnt_port == PORT_AUX) begin
      sel_we    = bus.aux_we;
      sel_addr  = bus.aux_addr;
      sel_wdata = bus.aux_wdata;
    end
`endif
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE:   if (grant) state_d = SETUP;
      SETUP: begin
        state_d = STROBE;
        cnt_d   = CNT_LOAD;
      end
      STROBE: begin
        if (cnt_q == 4'd0) state_d = HOLD;
        else               cnt_d   = cnt_q - 4'd1;
      end
      HOLD:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Access registers only move on a grant, so ADR and data stay put through HOLD.
  always_comb begin
    port_d    = port_q;
    we_d      = we_q;
    adr_d     = adr_q;
    dat_out_d = dat_out_q;
    if (grant) begin
      port_d = gnt_port;
      we_d   = sel_we;
      adr_d  = sel_addr;
      if (sel_we) dat_out_d = sel_wdata;
    end
  end

  // Pin outputs are decoded from the upcoming state so they are flop outputs in that state.
  assign rd_capture = (state_q == STROBE) && (cnt_q == 4'd0) && !we_q;

  always_comb begin
    cs_b_d      = (state_d == IDLE);
    oe_b_d      = !((state_d != IDLE) && !we_d);
    we_b_d      = !((state_d == STROBE) && we_d);
    dat_oe_d    = (state_d != IDLE) && we_d;
    cpu_ack_d   = (state_d == HOLD) && (port_d == PORT_CPU);
    cpu_rdata_d = (rd_capture && (port_q == PORT_CPU)) ? dat_in : cpu_rdata_q;
  end

  always_ff @(posedge clk100 or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      port_q      <= PORT_CPU;
      we_q        <= 1'b0;
      adr_q       <= '0;
      dat_out_q   <= 8'h00;
      cs_b_q      <= 1'b1;
      oe_b_q      <= 1'b1;
      we_b_q      <= 1'b1;
      dat_oe_q    <= 1'b0;
      cpu_ack_q   <= 1'b0;
      cpu_rdata_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      port_q      <= port_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      dat_out_q   <= dat_out_d;
      cs_b_q      <= cs_b_d;
      oe_b_q      <= oe_b_d;
      we_b_q      <= we_b_d;
      dat_oe_q    <= dat_oe_d;
      cpu_ack_q   <= cpu_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
    end
  end

`ifdef SRAM_ARB_AUX_EN
  logic       aux_ack_q, aux_ack_d;
  logic [7:0] aux_rdata_q, aux_rdata_d;

  always_comb begin
    aux_ack_d   = (state_d == HOLD) && (port_d == PORT_AUX);
    aux_rdata_d = (rd_capture && (port_q == PORT_AUX)) ? dat_in : aux_rdata_q;
  end

  always_ff @(posedge clk100 or posedge reset) begin
    if (reset) begin
      aux_ack_q   <= 1'b0;
      aux_rdata_q <= 8'h00;
    end else begin
      aux_ack_q   <= aux_ack_d;
      aux_rdata_q <= aux_rdata_d;
    end
  end

  assign bus.aux_ack   = aux_ack_q;
  assign bus.aux_rdata = aux_rdata_q;
`else
  assign bus.aux_ack   = 1'b0;
  assign bus.aux_rdata = 8'h00;
`endif

  assign bus.cpu_ack   = cpu_ack_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign RAMCS_b       = cs_b_q;
  assign RAMOE_b       = oe_b_q;
  assign RAMWE_b       = we_b_q;
  assign ADR           = adr_q;
  assign dat_out       = dat_out_q;
  assign dat_oe        = dat_oe_q;

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Sequencer and two-port arbiter for the external 256K×8 asynchronous SRAM on the Atom board, clocked from `clk100`. It replaces direct pin drive from the CPU bus. Two requesters share the SRAM:

- the CPU port (registered 6502 bus);
- an auxiliary port (loader/DMA).

Each granted access is sequenced through setup, strobe and hold phases, so WE_b never overlaps an address change and the data bus is never contended. The top level owns the bidirectional pad (SB_IO), driven from `dat_out`/`dat_oe`.

## Interface
Parameters:
- `ADDR_W`, 18, SRAM address width.
- `ACCESS_CYCLES`, 2, clk100 cycles in STROBE phase; legal range 1..15.

Ports:
- `clk100`  in  1  sole clock, 100 MHz.
- `reset`  in  1  asynchronous, active-high.
- `cpu_req`  in  1  CPU request level; held until `cpu_ack`.
- `cpu_we`  in  1  1 = write, 0 = read.
- `cpu_addr`  in  ADDR_W  access address.
- `cpu_wdata`  in  8  write data.
- `cpu_rdata`  out  8  read data; valid with `cpu_ack`, held until next CPU read completes.
- `cpu_ack`  out  1  one-cycle completion pulse.
- `aux_req`, `aux_we`, `aux_addr`, `aux_wdata`, `aux_rdata`, `aux_ack`  same as the CPU set, for the auxiliary port.
- `RAMCS_b`, `RAMOE_b`, `RAMWE_b`  out  1 each  SRAM strobes, active-low.
- `ADR`  out  ADDR_W  SRAM address.
- `dat_out`  out  8  pad output data.
- `dat_oe`  out  1  pad output enable.
- `dat_in`  in  8  pad input data.

## Operation
FSM states: IDLE, SETUP, STROBE, HOLD.

- **IDLE**
  - With no request, all strobes are high and `dat_oe`=0.
  - On any `req` high, the arbiter grants, latches that port's addr/we/wdata into the access registers, and goes to SETUP.
- **Arbitration**
  - A lone request wins.
  - If both ports request, the port not granted last wins (round-robin).
  - `last_grant` resets to aux, so the CPU wins the first tie.
- **SETUP** (1 cycle)
  - ADR is driven and RAMCS_b=0.
  - Read: RAMOE_b=0.
  - Write: `dat_oe`=1 and `dat_out`=wdata, with RAMOE_b=1.
  - Next state is STROBE; the strobe counter loads ACCESS_CYCLES-1.
- **STROBE** (ACCESS_CYCLES cycles)
  - Write: RAMWE_b=0.
  - Read: RAMOE_b stays 0.
  - The counter decrements each cycle. At counter 0, a read captures `dat_in` into the granted port's `rdata` and the FSM goes to HOLD.
- **HOLD** (1 cycle)
  - RAMWE_b=1, while ADR, CS and (for writes) `dat_oe` stay asserted.
  - The granted port's ack is high for this cycle only. Next state is IDLE.
- A requester must deassert `req`, or present a new request, on the edge after it sees ack. IDLE re-samples `req` one cycle later, so a still-held `req` starts a new access.
- ADR, `dat_out`, strobes, `dat_oe`, acks and `rdata` are all registered outputs, with no combinational path from inputs.
- Writes never update `rdata`.

## Timing
- Reset values:
  - RAMCS_b=1, RAMOE_b=1, RAMWE_b=1.
  - ADR=0, `dat_out`=0, `dat_oe`=0.
  - both acks=0, both rdata=0.
  - state=IDLE, last_grant=aux.
- Latency: when `req` is sampled high in IDLE at edge 0, ack is high in cycle ACCESS_CYCLES+2. Port throughput is one access per ACCESS_CYCLES+3 cycles (5 with the default).
- Read data is sampled at the end of the last STROBE cycle, so `dat_in` must settle within (ACCESS_CYCLES+1)×10 ns of ADR.
- WE_b falls at least 1 cycle after ADR/data are stable and rises 1 cycle before they change.
- A request arriving mid-access waits. The worst-case wait is one full access of the other port, then grant.
- Reset asserted mid-access abandons it immediately: strobes go high, `dat_oe`=0, no ack is issued, and the write may be incomplete.

## Configuration
- `SRAM_ARB_AUX_EN` defined: the aux port and round-robin arbitration are present as described.
- Undefined:
  - aux inputs are ignored;
  - `aux_ack`=0 and `aux_rdata`=0 constant;
  - the CPU always wins;
  - `last_grant` logic is removed.
- CPU timing is identical in both builds.

## Structure
- Shared package `atom_sram_pkg`:
  - state enum (IDLE/SETUP/STROBE/HOLD);
  - `SRAM_ADDR_W`=18;
  - port-id constants PORT_CPU=0 and PORT_AUX=1.
- One sub-module, `sram_rr_arb`: 2-input round-robin grant with `last_grant` register, updated only on IDLE→SETUP.
- The FSM, access registers and pin registers live in `sram_arbiter`.

## Test plan
- **CPU write then read:** write 0xA5 to 0x01234, then read 0x01234 with an SRAM model. Required: `cpu_rdata`=0xA5 with `cpu_ack` in cycle 4 after `req` (ACCESS_CYCLES=2), and WE_b low for exactly 2 cycles.
- **Simultaneous requests after reset:** CPU writes 0x11 to 0x00010 and aux writes 0x22 to 0x00020. Required: CPU acked first, aux acked 5 cycles later, and both locations are correct.
- **Continuous requests from both ports for 20 accesses:** required grants alternate CPU/aux with no port starving, and every ack is spaced 5 cycles apart.
- **Reset during STROBE of a write:** required: strobes high and `dat_oe`=0 immediately (asynchronous), no ack, and a normal access works after release.
- **Bus-contention check:** over a random mix of 200 reads and writes, `dat_oe`=1 never coincides with RAMOE_b=0, and ADR never changes while RAMWE_b=0.
- **Build without `SRAM_ARB_AUX_EN`:** `aux_req` is held high and CPU reads of 0x3FFFF return the model data. Required: `aux_ack` never asserts.
